// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned n x n shift-and-add multiplier
// Retires one multiplier bit per clock through a combinational adder; Done pulses with the new Product.

module adder #(
  parameter int n = 4
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] M,
  output logic [n-1:0] Sum,
  output logic         C
);

  assign {C, Sum} = {1'b0, A} + {1'b0, M};

endmodule

module shift_add_multiplier #(
  parameter int n = 4
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic           Start,
  input  logic [n-1:0]   Multiplicand,
  input  logic [n-1:0]   Multiplier,
  output logic [2*n-1:0] Product,
  output logic           Ready,
  output logic           Done
);

  localparam int CW = $clog2(n) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [n-1:0]    Mreg;
  logic [n-1:0]    Acc;
  logic [n-1:0]    Qreg;
  logic            Cy;
  logic [CW-1:0]   Count;
  logic [n-1:0]    Sum;
  logic            C;
  logic            last_iter;
  logic            carry_in;
  logic [n-1:0]    acc_in;
  logic [2*n:0]    shifted;

  adder #(.n(n)) u_adder (
    .A   (Acc),
    .M   (Mreg),
    .Sum (Sum),
    .C   (C)
  );

  // Cy is always zero between iterations, so it stands in for the 1'b0 fill
  always_comb begin
    carry_in = Cy;
    acc_in   = Acc;
    if (Qreg[0]) begin
      carry_in = C;
      acc_in   = Sum;
    end
    shifted = {carry_in, acc_in, Qreg} >> 1;
  end

  assign last_iter = (Count == CW'(n - 1));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = RUN;
      RUN:     if (last_iter) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Mreg    <= '0;
      Acc     <= '0;
      Qreg    <= '0;
      Cy      <= 1'b0;
      Count   <= '0;
      Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            Mreg  <= Multiplicand;
            Qreg  <= Multiplier;
            Acc   <= '0;
            Cy    <= 1'b0;
            Count <= '0;
          end
        end
        RUN: begin
          Cy    <= shifted[2*n];
          Acc   <= shifted[2*n-1:n];
          Qreg  <= shifted[n-1:0];
          Count <= Count + CW'(1);
          if (last_iter) begin
            Product <= shifted[2*n-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Ready = (state == IDLE);
  assign Done  = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier (n=4 and n=8)

module tb_shift_add_multiplier;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  logic        Clock = 1'b0;
  logic        nReset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  Multiplicand = '0;
  logic [3:0]  Multiplier = '0;
  logic [7:0]  Product;
  logic        Ready;
  logic        Done;

  logic        Start8 = 1'b0;
  logic [7:0]  M8 = '0;
  logic [7:0]  Q8 = '0;
  logic [15:0] Product8;
  logic        Ready8;
  logic        Done8;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [7:0]  last_prod = '0;
  exp_t        exp_q[$];

  shift_add_multiplier #(.n(4)) dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .Ready        (Ready),
    .Done         (Done)
  );

  shift_add_multiplier #(.n(8)) dut8 (
    .Clock        (Clock),
    .nReset       (nReset),
    .Start        (Start8),
    .Multiplicand (M8),
    .Multiplier   (Q8),
    .Product      (Product8),
    .Ready        (Ready8),
    .Done         (Done8)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops one expectation per Done pulse, otherwise Product must hold
  always @(negedge Clock) begin
    exp_t e;
    if (!nReset) begin
      exp_q.delete();
      last_prod = '0;
    end else if (Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("product", {24'd0, Product}, e.prod);
        check("done_latency", cyc, e.cyc);
      end
      last_prod = Product;
    end else begin
      check("product_hold", {24'd0, Product}, {24'd0, last_prod});
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !Ready; i++) @(negedge Clock);
    if (!Ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_mult(input logic [3:0] m, input logic [3:0] q);
    wait_ready();
    Start        = 1'b1;
    Multiplicand = m;
    Multiplier   = q;
    exp_q.push_back('{prod: 32'(m) * 32'(q), cyc: cyc + 1 + 4});
    @(negedge Clock);
    Start        = 1'b0;
    Multiplicand = 4'($urandom_range(0, 15));
    Multiplier   = 4'($urandom_range(0, 15));
    check("ready_low_in_run", {31'd0, Ready}, 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !Done; i++) @(negedge Clock);
    if (!Done) check("done_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] dm [6] = '{4'd3, 4'd15, 4'd15, 4'd1, 4'd0, 4'd9};
  logic [3:0] dq [6] = '{4'd5, 4'd15, 4'd1, 4'd15, 4'd9, 4'd0};

  initial begin
    int s8;
    #1 nReset = 1'b0;
    #1;
    check("reset_product", {24'd0, Product}, 32'd0);
    check("reset_ready", {31'd0, Ready}, 32'd1);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_product8", {16'd0, Product8}, 32'd0);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);

    // 3 x 5 with the Ready-return check, then the remaining directed vectors
    do_mult(dm[0], dq[0]);
    wait_done();
    check("directed_product_3x5", {24'd0, Product}, 32'd15);
    @(negedge Clock);
    check("ready_after_done", {31'd0, Ready}, 32'd1);
    check("done_one_cycle", {31'd0, Done}, 32'd0);
    for (int i = 1; i < 6; i++) do_mult(dm[i], dq[i]);
    wait_done();
    @(negedge Clock);

    // Start held high across the whole sweep; operands scrambled during RUN/DONE
    wait_ready();
    Start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      check("sweep_ready", {31'd0, Ready}, 32'd1);
      Multiplicand = pair[7:4];
      Multiplier   = pair[3:0];
      exp_q.push_back('{prod: 32'(pair[7:4]) * 32'(pair[3:0]), cyc: cyc + 1 + 4});
      repeat (6) begin
        @(negedge Clock);
        Multiplicand = 4'($urandom_range(0, 15));
        Multiplier   = 4'($urandom_range(0, 15));
      end
    end
    Start = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clock);
    check("sweep_drain", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a 7 x 9 run
    do_mult(4'd7, 4'd9);
    @(negedge Clock);
    @(posedge Clock);
    #2 nReset = 1'b0;
    #1;
    check("abort_product", {24'd0, Product}, 32'd0);
    check("abort_ready", {31'd0, Ready}, 32'd1);
    check("abort_done", {31'd0, Done}, 32'd0);
    @(negedge Clock);
    #1 nReset = 1'b1;
    @(negedge Clock);
    do_mult(4'd7, 4'd9);
    wait_done();
    check("after_abort_7x9", {24'd0, Product}, 32'd63);
    @(negedge Clock);

    // n = 8 instance, 255 x 255
    for (int i = 0; i < 20 && !Ready8; i++) @(negedge Clock);
    Start8 = 1'b1;
    M8     = 8'd255;
    Q8     = 8'd255;
    s8     = cyc + 1;
    @(negedge Clock);
    Start8 = 1'b0;
    M8     = 8'd0;
    Q8     = 8'd0;
    for (int i = 0; i < 30 && !Done8; i++) @(negedge Clock);
    check("n8_done_seen", {31'd0, Done8}, 32'd1);
    check("n8_product", {16'd0, Product8}, 32'd65025);
    check("n8_latency", cyc - s8, 32'd8);
    @(negedge Clock);
    check("n8_ready_back", {31'd0, Ready8}, 32'd1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clock);
    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
